// File: rtl/ddr5_bank_cmd_sequencer.sv
// In-order DDR5 command sequencer: tracks the open row per bank and issues PRE/ACT/CAS
// under an open-page policy while honouring tRCD, tRP, tRAS, read-to-PRE and write-to-PRE.
module ddr5_bank_cmd_sequencer #(
   parameter int unsigned T_RCD = 39,
   parameter int unsigned T_RP  = 39,
   parameter int unsigned T_RAS = 76,
   parameter int unsigned T_RTP = 18,
   parameter int unsigned T_WTP = 84
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [33:0] req_addr,
   input  logic [1:0]  req_op,
   output logic        cmd_valid,
   output logic [2:0]  cmd_code,
   output logic        cmd_channel,
   output logic [2:0]  cmd_bg,
   output logic [1:0]  cmd_bank,
   output logic [15:0] cmd_row,
   output logic [9:0]  cmd_col,
   output logic        busy
);

   localparam int unsigned NBANK = 64;
   localparam int unsigned IDXW  = 6;
   localparam int unsigned ROWW  = 16;
   localparam int unsigned COLW  = 10;
   localparam int unsigned PCW   = 7;
   localparam int unsigned WTW   = 7;

   localparam logic [2:0] C_NOP = 3'd0, C_ACT0 = 3'd1, C_ACT1 = 3'd2, C_RD0 = 3'd3,
                          C_RD1 = 3'd4, C_WR0  = 3'd5, C_WR1  = 3'd6, C_PRE = 3'd7;

   // Each state names what is on the command bus during that cycle.
   typedef enum logic [3:0] {
      S_IDLE, S_LOOKUP, S_WAIT_PRE, S_PRE, S_WAIT_RP,
      S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1
   } state_t;

   state_t state, state_next;

   logic                   ch_q, wr_q;
   logic [2:0]             bg_q;
   logic [1:0]             bank_q;
   logic [ROWW-1:0]        row_q;
   logic [COLW-1:0]        col_q;
   logic [WTW-1:0]         wt;
   logic [NBANK-1:0]       open_q;
   logic [NBANK-1:0][ROWW-1:0] row_tbl;
   logic [NBANK-1:0][PCW-1:0]  pre_cnt;

   logic [IDXW-1:0] idx;
   logic            sel_open, sel_hit, pre_ok;
   logic [PCW-1:0]  sel_pre_dec;
   logic            accept;
   logic            unused_byte;

   logic [2:0]      code_next;
   logic            valid_next, ch_next;
   logic [2:0]      bg_next;
   logic [1:0]      bank_next;
   logic [ROWW-1:0] row_next;
   logic [COLW-1:0] col_next;

   assign unused_byte = ^req_addr[1:0];
   assign accept      = req_valid && req_ready;
   assign idx         = {ch_q, bg_q, bank_q};
   assign sel_open    = open_q[idx];
   assign sel_hit     = sel_open && (row_tbl[idx] == row_q);
   // PRE goes out next cycle, when the counter will have reached zero
   assign pre_ok      = pre_cnt[idx] <= PCW'(1);
   assign sel_pre_dec = (pre_cnt[idx] != '0) ? pre_cnt[idx] - PCW'(1) : '0;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:     if (accept) state_next = S_LOOKUP;
         S_LOOKUP: begin
            if (!sel_open)    state_next = S_ACT0;
            else if (sel_hit) state_next = S_CAS0;
            else if (pre_ok)  state_next = S_PRE;
            else              state_next = S_WAIT_PRE;
         end
         S_WAIT_PRE:         if (pre_ok) state_next = S_PRE;
         S_PRE, S_WAIT_RP:   state_next = (wt == '0) ? S_ACT0 : S_WAIT_RP;
         S_ACT0:             state_next = S_ACT1;
         S_ACT1, S_WAIT_RCD: state_next = (wt == '0) ? S_CAS0 : S_WAIT_RCD;
         S_CAS0:             state_next = S_CAS1;
         S_CAS1:             state_next = S_IDLE;
         default:            state_next = S_IDLE;
      endcase
   end

   // Command decode for the cycle being entered
   always_comb begin
      code_next = C_NOP;
      row_next  = '0;
      col_next  = '0;
      unique case (state_next)
         S_PRE:  code_next = C_PRE;
         S_ACT0: begin code_next = C_ACT0; row_next = row_q; end
         S_ACT1: begin code_next = C_ACT1; row_next = row_q; end
         S_CAS0: begin code_next = wr_q ? C_WR0 : C_RD0; col_next = col_q; end
         S_CAS1: begin code_next = wr_q ? C_WR1 : C_RD1; col_next = col_q; end
         default: ;
      endcase
      valid_next = code_next != C_NOP;
      ch_next    = valid_next ? ch_q   : 1'b0;
      bg_next    = valid_next ? bg_q   : 3'd0;
      bank_next  = valid_next ? bank_q : 2'd0;
   end

   // Registered command bus and handshake
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cmd_valid   <= 1'b0;
         cmd_code    <= C_NOP;
         cmd_channel <= 1'b0;
         cmd_bg      <= '0;
         cmd_bank    <= '0;
         cmd_row     <= '0;
         cmd_col     <= '0;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
      end else begin
         cmd_valid   <= valid_next;
         cmd_code    <= code_next;
         cmd_channel <= ch_next;
         cmd_bg      <= bg_next;
         cmd_bank    <= bank_next;
         cmd_row     <= row_next;
         cmd_col     <= col_next;
         req_ready   <= state_next == S_IDLE;
         busy        <= state_next != S_IDLE;
      end
   end

   // Request latch and tRP/tRCD wait timer
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ch_q   <= 1'b0;
         wr_q   <= 1'b0;
         bg_q   <= '0;
         bank_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
         wt     <= '0;
      end else begin
         if (state == S_IDLE && accept) begin
            row_q  <= req_addr[33:18];
            col_q  <= {req_addr[17:12], req_addr[5:2]};
            bank_q <= req_addr[11:10];
            bg_q   <= req_addr[9:7];
            ch_q   <= req_addr[6];
            wr_q   <= req_op == 2'd1;
         end
         if (code_next == C_ACT0)     wt <= WTW'(T_RCD - 1);
         else if (code_next == C_PRE) wt <= WTW'(T_RP - 1);
         else if (wt != '0)           wt <= wt - WTW'(1);
      end
   end

   // Bank table: every bank's PRE counter runs every cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         open_q  <= '0;
         row_tbl <= '0;
         pre_cnt <= '0;
      end else begin
         for (int i = 0; i < NBANK; i++) begin
            if (pre_cnt[i] != '0) pre_cnt[i] <= pre_cnt[i] - PCW'(1);
         end
         unique case (code_next)
            C_ACT0: begin
               open_q[idx]  <= 1'b1;
               row_tbl[idx] <= row_q;
               pre_cnt[idx] <= PCW'(T_RAS);
            end
            C_PRE: open_q[idx] <= 1'b0;
            C_RD1: pre_cnt[idx] <= (sel_pre_dec > PCW'(T_RTP)) ? sel_pre_dec : PCW'(T_RTP);
            C_WR1: pre_cnt[idx] <= (sel_pre_dec > PCW'(T_WTP)) ? sel_pre_dec : PCW'(T_WTP);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr5_bank_cmd_sequencer.sv
// Bench for ddr5_bank_cmd_sequencer: directed scenarios plus random traffic, checked every
// cycle against a schedule predicted from absolute-cycle bank timing rules.
module tb_ddr5_bank_cmd_sequencer;

   localparam int T_RCD = 39;
   localparam int T_RP  = 39;
   localparam int T_RAS = 76;
   localparam int T_RTP = 18;
   localparam int T_WTP = 84;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [33:0] req_addr = '0;
   logic [1:0]  req_op = '0;
   logic        cmd_valid;
   logic [2:0]  cmd_code;
   logic        cmd_channel;
   logic [2:0]  cmd_bg;
   logic [1:0]  cmd_bank;
   logic [15:0] cmd_row;
   logic [9:0]  cmd_col;
   logic        busy;

   ddr5_bank_cmd_sequencer dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_op(req_op), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .cmd_channel(cmd_channel), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
      .cmd_col(cmd_col), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [35:0] bus;
   } exp_t;

   exp_t q[$];
   bit   m_open[64];
   int   m_row[64];
   int   m_pre_at[64];
   int   ready_at = 0;
   bit   junk = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 64; i++) begin
         m_open[i] = 1'b0; m_row[i] = 0; m_pre_at[i] = 0;
      end
      ready_at = cyc;
   endtask

   task automatic push(input int c, input logic [2:0] code, input logic [33:0] a,
                       input logic [15:0] row, input logic [9:0] col);
      exp_t e;
      e.cyc = c;
      e.bus = {1'b1, code, a[6], a[9:7], a[11:10], row, col};
      q.push_back(e);
   endtask

   // Predicts the full command schedule of a request accepted in cycle acc
   task automatic model_accept(input logic [33:0] a, input logic [1:0] op, input int acc);
      int          idx, r, pre, act, cas;
      bit          w;
      logic [9:0]  col;
      idx = {a[6], a[9:7], a[11:10]};
      r   = int'(a[33:18]);
      col = {a[17:12], a[5:2]};
      w   = (op == 2'd1);
      pre = -1;
      act = -1;
      if (m_open[idx] && m_row[idx] == r) begin
         cas = acc + 2;
      end else begin
         if (m_open[idx]) begin
            pre = imax(acc + 2, m_pre_at[idx]);
            act = pre + T_RP;
         end else begin
            act = acc + 2;
         end
         cas = act + T_RCD;
      end
      if (pre >= 0) push(pre, 3'd7, a, 16'd0, 10'd0);
      if (act >= 0) begin
         push(act, 3'd1, a, a[33:18], 10'd0);
         push(act + 1, 3'd2, a, a[33:18], 10'd0);
         m_open[idx]   = 1'b1;
         m_row[idx]    = r;
         m_pre_at[idx] = act + T_RAS;
      end
      push(cas, w ? 3'd5 : 3'd3, a, 16'd0, col);
      push(cas + 1, w ? 3'd6 : 3'd4, a, 16'd0, col);
      m_pre_at[idx] = imax(m_pre_at[idx], cas + 1 + (w ? T_WTP : T_RTP));
      ready_at = cas + 2;
   endtask

   function automatic logic [33:0] raddr();
      logic [33:0] a;
      a = {16'($urandom_range(0, 2)), 6'($urandom), 2'($urandom_range(0, 1)),
           3'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom)};
      return a;
   endfunction

   // Advance to the middle of the next cycle and check every output
   task automatic tick();
      logic [35:0] e;
      @(negedge clock);
      e = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q[0].bus;
         void'(q.pop_front());
      end
      chk("cmd", 64'({cmd_valid, cmd_code, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col}),
          64'(e));
      chk("ready_busy", 64'({busy, req_ready}), (cyc >= ready_at) ? 64'd1 : 64'd2);
      if (junk && cyc < ready_at) begin
         req_valid = 1'b1;
         req_addr  = 34'($urandom) ^ {$urandom, 2'b00};
         req_op    = 2'($urandom);
      end else begin
         req_valid = 1'b0;
      end
   endtask

   task automatic send(input logic [33:0] a, input logic [1:0] op);
      int guard;
      guard = 0;
      while (cyc < ready_at && guard < 1000) begin
         tick();
         guard++;
      end
      req_valid = 1'b1;
      req_addr  = a;
      req_op    = op;
      model_accept(a, op, cyc);
      tick();
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((q.size() > 0 || cyc < ready_at) && guard < 1000) begin
         tick();
         guard++;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Closed bank, row hit, then conflict on bank 0
      send(34'h0_0000_0000, 2'd0);
      send(34'h0_0000_1000, 2'd0);
      send(34'h0_0004_0000, 2'd1);
      drain();

      // Back to row 0, write hit, closed bg1, bg0 row still open
      send(34'h0_0000_0000, 2'd0);
      send(34'h0_0000_0000, 2'd1);
      send(34'h0_0000_0080, 2'd0);
      send(34'h0_0000_0010, 2'd2);
      drain();

      // Reset while waiting out tRCD
      send(34'h0_0000_0400, 2'd0);
      repeat (10) tick();
      reset_n = 1'b0;
      #1;
      chk("reset_cmd", 64'({cmd_valid, cmd_code}), 64'd0);
      chk("reset_ready", 64'({busy, req_ready}), 64'd1);
      model_reset();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      send(34'h0_0000_0400, 2'd3);
      drain();

      // Changing requests held while busy must be ignored
      junk = 1'b1;
      send(34'h0_0004_0400, 2'd1);
      send(34'h0_0004_0400, 2'd0);
      drain();

      for (int i = 0; i < 60; i++) begin
         junk = 1'($urandom);
         send(raddr(), 2'($urandom));
         repeat ($urandom_range(0, 3)) tick();
      end
      junk = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
